// File: rtl/display_pkg.sv
// Shared encodings, display constants and two-digit BCD helpers for the display sequencer.
package display_pkg;

   localparam int unsigned ST_W   = 2;
   localparam int unsigned DIG_W  = 4;
   localparam int unsigned LED_W  = 10;
   localparam int unsigned BCD2_W = 8;

   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_PLAY = 2'd1;
   localparam logic [ST_W-1:0] ST_OVER = 2'd2;

   localparam logic [DIG_W-1:0] BLANK    = 4'hF;
   localparam logic [LED_W-1:0] LED_ALL  = 10'h3FF;
   localparam logic [LED_W-1:0] LED_NONE = 10'h000;

   localparam logic [BCD2_W-1:0] BCD_MAX = 8'h99;
   localparam logic [BCD2_W-1:0] BCD_MIN = 8'h00;

   // Everything driven to the board except hex0, which simply tracks mode.
   typedef struct packed {
      logic [DIG_W-1:0] hex5;
      logic [DIG_W-1:0] hex4;
      logic [DIG_W-1:0] hex3;
      logic [DIG_W-1:0] hex2;
      logic [LED_W-1:0] ledr;
   } disp_t;

   localparam disp_t DISP_BLANK = '{
      hex5: BLANK,
      hex4: BLANK,
      hex3: BLANK,
      hex2: BLANK,
      ledr: LED_NONE
   };

   // Increment that carries 09 -> 10 and sticks at 99.
   function automatic logic [BCD2_W-1:0] bcd_inc_sat(input logic [BCD2_W-1:0] v);
      logic [BCD2_W-1:0] r;
      if (v == BCD_MAX) begin
         r = v;
      end else if (v[3:0] >= 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   // Decrement that borrows 10 -> 09 and sticks at 00.
   function automatic logic [BCD2_W-1:0] bcd_dec_sat(input logic [BCD2_W-1:0] v);
      logic [BCD2_W-1:0] r;
      if (v == BCD_MIN) begin
         r = v;
      end else if (v[3:0] == 4'd0) begin
         r = {v[7:4] - 4'd1, 4'd9};
      end else begin
         r = {v[7:4], v[3:0] - 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter: load wins over up, up wins over down; both directions saturate.
module bcd2_counter
   import display_pkg::*;
#(
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [7:0]  i_load_val,
   input  logic        i_up,
   input  logic        i_down,
   output logic [7:0]  o_value
);

   logic [BCD2_W-1:0] r_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= RESET_VAL;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_up) begin
         r_value <= bcd_inc_sat(r_value);
      end else if (i_down) begin
         r_value <= bcd_dec_sat(r_value);
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/display_sequencer.sv
// Game display sequencer: IDLE/PLAY/OVER control of the countdown, score,
// seven-segment digit holders and LED bar, with match flash and game-over blink.
module display_sequencer
   import display_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 50_000_000,
   parameter int unsigned BLINK_DIV    = 12_500_000,
   parameter logic [7:0]  START_TIME   = 8'h60,
   parameter int unsigned FLASH_CYCLES = 25_000_000
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        userquit,
   input  logic        ingameOn,
   input  logic        gameOver,
   input  logic [3:0]  mode,
   input  logic        match_pulse,
   input  logic [9:0]  tile_mask,
   output logic [3:0]  hex0hldr,
   output logic [3:0]  hex2hldr,
   output logic [3:0]  hex3hldr,
   output logic [3:0]  hex4hldr,
   output logic [3:0]  hex5hldr,
   output logic [9:0]  ledrhldr
);

   localparam int unsigned TICK_W  = (TICK_DIV > 1)     ? $clog2(TICK_DIV)         : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV > 1)    ? $clog2(BLINK_DIV)        : 1;
   localparam int unsigned FLASH_W = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;

   logic [ST_W-1:0]    r_state;
   logic [ST_W-1:0]    w_state_nxt;

   logic [TICK_W-1:0]  r_tick_cnt;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_blink;
   logic [FLASH_W-1:0] r_flash_cnt;

   logic [BCD2_W-1:0]  w_timer;
   logic [BCD2_W-1:0]  w_score;

   disp_t              w_disp;
   disp_t              r_disp;
   logic [DIG_W-1:0]   r_hex0;

   logic               w_quit;
   logic               w_in_play;
   logic               w_in_over;
   logic               w_tick;
   logic               w_expire;
   logic               w_play_entry;
   logic               w_score_up;
   logic               w_flashing;

   assign w_quit       = userquit || !ingameOn;
   assign w_in_play    = (r_state == ST_PLAY);
   assign w_in_over    = (r_state == ST_OVER);
   assign w_tick       = w_in_play && (r_tick_cnt == TICK_W'(TICK_DIV - 1));
   // The tick that takes the countdown from 01 to 00 also ends the game.
   assign w_expire     = w_tick && (w_timer <= 8'h01);
   assign w_play_entry = (r_state == ST_IDLE) && (w_state_nxt == ST_PLAY);
   assign w_score_up   = w_in_play && match_pulse;
   assign w_flashing   = (r_flash_cnt != '0);

   // State register.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; quitting outranks every other exit.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (ingameOn && !gameOver && !userquit) begin
               w_state_nxt = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (w_quit) begin
               w_state_nxt = ST_IDLE;
            end else if (gameOver || w_expire) begin
               w_state_nxt = ST_OVER;
            end
         end
         ST_OVER: begin
            if (w_quit) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Seconds prescaler; idles at zero outside PLAY so every entry starts a fresh second.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_tick_cnt <= '0;
      end else if (!w_in_play || w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
   end

   // Match flash window, restarted by every counted match.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_flash_cnt <= '0;
      end else if (!w_in_play) begin
         r_flash_cnt <= '0;
      end else if (match_pulse) begin
         r_flash_cnt <= FLASH_W'(FLASH_CYCLES);
      end else if (w_flashing) begin
         r_flash_cnt <= r_flash_cnt - FLASH_W'(1);
      end
   end

   // Blink phase sits at 1 outside OVER, so OVER always opens in the visible phase.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_blink     <= 1'b1;
         r_blink_cnt <= '0;
      end else if (!w_in_over) begin
         r_blink     <= 1'b1;
         r_blink_cnt <= '0;
      end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         r_blink     <= ~r_blink;
         r_blink_cnt <= '0;
      end else begin
         r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
   end

   bcd2_counter #(
      .RESET_VAL (START_TIME)
   ) u_timer (
      .clk        (CLOCK_50),
      .rst_n      (resetn),
      .i_load     (w_play_entry),
      .i_load_val (START_TIME),
      .i_up       (1'b0),
      .i_down     (w_tick),
      .o_value    (w_timer)
   );

   bcd2_counter #(
      .RESET_VAL (8'h00)
   ) u_score (
      .clk        (CLOCK_50),
      .rst_n      (resetn),
      .i_load     (w_play_entry),
      .i_load_val (BCD_MIN),
      .i_up       (w_score_up),
      .i_down     (1'b0),
      .o_value    (w_score)
   );

   // Display content for the current state, registered below.
   always_comb begin
      w_disp = DISP_BLANK;
      case (r_state)
         ST_PLAY: begin
            w_disp.hex5 = w_timer[7:4];
            w_disp.hex4 = w_timer[3:0];
            w_disp.hex3 = w_score[7:4];
            w_disp.hex2 = w_score[3:0];
            w_disp.ledr = w_flashing ? LED_ALL : tile_mask;
         end
         ST_OVER: begin
            if (r_blink) begin
               w_disp.hex5 = w_score[7:4];
               w_disp.hex4 = w_score[3:0];
               w_disp.ledr = LED_ALL;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_disp <= DISP_BLANK;
         r_hex0 <= BLANK;
      end else begin
         r_disp <= w_disp;
         r_hex0 <= mode;
      end
   end

   assign hex0hldr = r_hex0;
   assign hex2hldr = r_disp.hex2;
   assign hex3hldr = r_disp.hex3;
   assign hex4hldr = r_disp.hex4;
   assign hex5hldr = r_disp.hex5;
   assign ledrhldr = r_disp.ledr;

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized bench for display_sequencer: two instances (short and long countdown) share
// stimulus and are compared every cycle against a seconds/score/elapsed-time model.
module tb_display_sequencer;

   localparam int TICK_DIV     = 4;
   localparam int BLINK_DIV    = 3;
   localparam int FLASH_CYCLES = 2;
   localparam logic [3:0] BL   = 4'hF;

   logic       CLOCK_50;
   logic       resetn;
   logic       userquit;
   logic       ingameOn;
   logic       gameOver;
   logic [3:0] mode;
   logic       match_pulse;
   logic [9:0] tile_mask;

   logic [3:0] a_hex0, a_hex2, a_hex3, a_hex4, a_hex5;
   logic [9:0] a_ledr;
   logic [3:0] b_hex0, b_hex2, b_hex3, b_hex4, b_hex5;
   logic [9:0] b_ledr;

   logic [29:0] obs [2];
   assign obs[0] = {a_hex5, a_hex4, a_hex3, a_hex2, a_hex0, a_ledr};
   assign obs[1] = {b_hex5, b_hex4, b_hex3, b_hex2, b_hex0, b_ledr};

   display_sequencer #(
      .TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .START_TIME(8'h03), .FLASH_CYCLES(FLASH_CYCLES)
   ) u_dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .userquit(userquit), .ingameOn(ingameOn),
      .gameOver(gameOver), .mode(mode), .match_pulse(match_pulse), .tile_mask(tile_mask),
      .hex0hldr(a_hex0), .hex2hldr(a_hex2), .hex3hldr(a_hex3), .hex4hldr(a_hex4),
      .hex5hldr(a_hex5), .ledrhldr(a_ledr)
   );

   display_sequencer #(
      .TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV), .START_TIME(8'h99), .FLASH_CYCLES(FLASH_CYCLES)
   ) u_dut_long (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .userquit(userquit), .ingameOn(ingameOn),
      .gameOver(gameOver), .mode(mode), .match_pulse(match_pulse), .tile_mask(tile_mask),
      .hex0hldr(b_hex0), .hex2hldr(b_hex2), .hex3hldr(b_hex3), .hex4hldr(b_hex4),
      .hex5hldr(b_hex5), .ledrhldr(b_ledr)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks;
   int n_errors;
   int cyc;

   // Model: 0 idle, 1 play, 2 over; time kept as elapsed cycles, values as plain integers.
   int m_st    [2];
   int m_play  [2];
   int m_over  [2];
   int m_score [2];
   int m_age   [2];
   int start_sec [2];
   logic [29:0] m_exp [2];

   task automatic check_eq(input string tag, input logic [29:0] got, input logic [29:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [29:0] pack(input logic [3:0] h5, input logic [3:0] h4,
                                        input logic [3:0] h3, input logic [3:0] h2,
                                        input logic [3:0] h0, input logic [9:0] led);
      return {h5, h4, h3, h2, h0, led};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i]    = 0;
         m_play[i]  = 0;
         m_over[i]  = 0;
         m_score[i] = 0;
         m_age[i]   = FLASH_CYCLES;
         m_exp[i]   = pack(BL, BL, BL, BL, BL, 10'h000);
      end
   endtask

   // One rising edge: outputs reflect the pre-edge view, then the state advances.
   task automatic model_edge();
      int  tmr;
      bit  ph;
      bit  quit;
      quit = userquit || !ingameOn;
      for (int i = 0; i < 2; i++) begin
         tmr = start_sec[i] - m_play[i] / TICK_DIV;
         ph  = ((m_over[i] / BLINK_DIV) % 2) == 0;
         case (m_st[i])
            0: m_exp[i] = pack(BL, BL, BL, BL, mode, 10'h000);
            1: m_exp[i] = pack(4'(tmr / 10), 4'(tmr % 10), 4'(m_score[i] / 10),
                               4'(m_score[i] % 10), mode,
                               (m_age[i] < FLASH_CYCLES) ? 10'h3FF : tile_mask);
            default: m_exp[i] = ph ? pack(4'(m_score[i] / 10), 4'(m_score[i] % 10), BL, BL, mode, 10'h3FF)
                                   : pack(BL, BL, BL, BL, mode, 10'h000);
         endcase
         case (m_st[i])
            0: begin
               if (ingameOn && !gameOver && !userquit) begin
                  m_st[i]    = 1;
                  m_play[i]  = 0;
                  m_score[i] = 0;
                  m_age[i]   = FLASH_CYCLES;
               end
            end
            1: begin
               if (match_pulse) begin
                  if (m_score[i] < 99) m_score[i]++;
                  m_age[i] = 0;
               end else if (m_age[i] < FLASH_CYCLES) begin
                  m_age[i]++;
               end
               m_play[i]++;
               if (quit) begin
                  m_st[i] = 0;
               end else if (gameOver || (start_sec[i] - m_play[i] / TICK_DIV) <= 0) begin
                  m_st[i]   = 2;
                  m_over[i] = 0;
               end
            end
            default: begin
               m_over[i]++;
               if (quit) m_st[i] = 0;
            end
         endcase
      end
   endtask

   task automatic rand_inputs(input int p_in, input int p_quit, input int p_over, input int p_match);
      ingameOn    = ($urandom_range(99) < p_in);
      userquit    = ($urandom_range(99) < p_quit);
      gameOver    = ($urandom_range(99) < p_over);
      match_pulse = ($urandom_range(99) < p_match);
      mode        = 4'($urandom);
      tile_mask   = 10'($urandom);
   endtask

   task automatic step(input string tag);
      @(posedge CLOCK_50);
      model_edge();
      @(negedge CLOCK_50);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("%s c%0d u%0d", tag, cyc, i), obs[i], m_exp[i]);
      end
      cyc++;
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("%s u%0d", tag, i), obs[i], m_exp[i]);
      end
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      cyc          = 0;
      start_sec[0] = 3;
      start_sec[1] = 99;
      CLOCK_50     = 1'b0;
      resetn       = 1'b0;
      userquit     = 1'b0;
      ingameOn     = 1'b0;
      gameOver     = 1'b0;
      match_pulse  = 1'b0;
      mode         = 4'h0;
      tile_mask    = 10'h000;
      model_reset();

      repeat (3) @(negedge CLOCK_50);
      ingameOn = 1'b1;
      mode     = 4'h7;
      #1;
      check_reset("reset_hold");
      @(negedge CLOCK_50);
      resetn = 1'b1;

      // Countdown to expiry on the short instance, with flashes mixed in.
      for (int k = 0; k < 30; k++) begin
         rand_inputs(100, 0, 0, 60);
         step("play");
      end
      // Continuous matches drive the long instance to saturation.
      for (int k = 0; k < 120; k++) begin
         rand_inputs(100, 0, 0, 100);
         step("saturate");
      end
      rand_inputs(100, 0, 100, 0);
      step("game_over");
      for (int k = 0; k < 15; k++) begin
         rand_inputs(100, 0, 0, 50);
         step("over_blink");
      end
      rand_inputs(0, 0, 0, 0);
      step("leave_over");
      for (int k = 0; k < 6; k++) begin
         rand_inputs(100, 0, 0, 50);
         step("replay");
      end
      rand_inputs(100, 100, 100, 0);
      step("quit_with_over");
      for (int k = 0; k < 2; k++) begin
         rand_inputs(0, 0, 0, 50);
         step("idle");
      end

      for (int k = 0; k < 2000; k++) begin
         rand_inputs(92, 3, 3, 35);
         step("random");
      end

      // Abort mid-PLAY with an asynchronous reset.
      rand_inputs(0, 0, 0, 0);
      step("pre_abort");
      for (int k = 0; k < 3; k++) begin
         rand_inputs(100, 0, 0, 100);
         step("pre_abort_play");
      end
      resetn = 1'b0;
      #1;
      model_reset();
      check_reset("reset_mid_play");
      @(negedge CLOCK_50);
      check_reset("reset_held");
      resetn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         rand_inputs(100, 0, 0, 40);
         step("after_reset");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, SHALL set the CLOCK_50 cycles per game-timer tick (1 Hz).
REQ-002 Parameter BLINK_DIV, default 12_500_000, SHALL set the CLOCK_50 cycles per game-over blink phase toggle.
REQ-003 Parameter START_TIME, default 8'h60, SHALL set the two-digit BCD value loaded into the countdown.
REQ-004 Parameter FLASH_CYCLES, default 25_000_000, SHALL set the length of the LED match-flash window in cycles.
REQ-005 CLOCK_50  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 resetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 userquit  in  1  SHALL be a level request to abandon the game and return to IDLE.
REQ-008 ingameOn  in  1  SHALL be a level meaning the game logic requests play.
REQ-009 gameOver  in  1  SHALL be a level meaning the game logic declares the game finished.
REQ-010 mode  in  4  SHALL be the mode code shown on hex0hldr.
REQ-011 match_pulse  in  1  SHALL be a one-cycle score-increment request.
REQ-012 tile_mask  in  10  SHALL be the LED pattern requested by the game logic.
REQ-013 hex0hldr, hex2hldr, hex3hldr, hex4hldr, hex5hldr  out  4 each  SHALL be the registered digit codes (4'hF = blank).
REQ-014 ledrhldr  out  10  SHALL be the registered LED pattern.

Function
REQ-015 The FSM SHALL have states IDLE, PLAY and OVER.
REQ-016 IDLE->PLAY SHALL occur when ingameOn=1, gameOver=0 and userquit=0.
REQ-017 PLAY->OVER SHALL occur when gameOver=1 or the timer decrements to 8'h00.
REQ-018 PLAY->IDLE and OVER->IDLE SHALL occur when userquit=1 or ingameOn=0; this takes priority over every other transition.
REQ-019 On PLAY entry, the timer SHALL load START_TIME, score SHALL clear to 8'h00, and the tick and flash counters SHALL clear.
REQ-020 In PLAY, the timer SHALL decrement by one BCD count every TICK_DIV cycles, with correct borrow (8'h10 -> 8'h09).
REQ-021 Score SHALL increment by one BCD count per match_pulse in PLAY only, with carry 8'h09 -> 8'h10, saturating at 8'h99.
REQ-022 A match_pulse on the cycle the timer reaches 00 SHALL still be counted.
REQ-023 match_pulse in IDLE or OVER SHALL be ignored.
REQ-024 hex0hldr SHALL follow mode in every state, with one cycle of latency.
REQ-025 IDLE display: hex2..hex5 SHALL be 4'hF and ledrhldr SHALL be 0.
REQ-026 PLAY display: hex5/hex4 SHALL show the timer tens/units, hex3/hex2 SHALL show the score tens/units, and ledrhldr SHALL show tile_mask.
REQ-027 Each match_pulse in PLAY SHALL (re)start a FLASH_CYCLES window during which ledrhldr = 10'h3FF, overriding tile_mask.
REQ-028 OVER display: hex3/hex2 SHALL be 4'hF; hex5/hex4 SHALL show the final score when the blink phase is 1 and 4'hF when it is 0; ledrhldr SHALL be 10'h3FF or 10'h000, following the blink phase.
REQ-029 The blink phase SHALL be set to 1 on OVER entry and SHALL toggle every BLINK_DIV cycles.
REQ-030 Score and timer SHALL hold their values in OVER; both SHALL be reinitialised only on the next PLAY entry.
REQ-031 All outputs SHALL be registered; display latency from a state or counter change SHALL be exactly one cycle.

Reset
REQ-032 While resetn=0, the sequencer SHALL be in IDLE, with all hex holders at 4'hF, ledrhldr at 0, timer at START_TIME, score at 0, all counters at 0 and the blink phase at 1.
REQ-033 Reset asserted mid-PLAY or mid-OVER SHALL abort immediately with no residual flash or blink.

Structure
REQ-034 Package display_pkg SHALL hold the state encoding, the BLANK constant (4'hF) and the LED_ALL constant (10'h3FF).
REQ-035 One sub-module, bcd2_counter, SHALL be used: a two-digit BCD counter with load, up-saturate and down inputs, instanced once for the timer and once for the score.

Verification (TICK_DIV=4, BLINK_DIV=3, FLASH_CYCLES=2, START_TIME=8'h03)
REQ-036 Reset, then ingameOn=1 -> one cycle later hex5..hex2 = 0,3,0,0; after 12 cycles, timer 00 -> OVER with hex3/hex2 = F.
REQ-037 Eleven match_pulses in PLAY -> hex3/hex2 = 1,1; ledrhldr = 3FF for 2 cycles after each pulse, then tile_mask.
REQ-038 100 match_pulses -> score saturates at 9,9.
REQ-039 In OVER with score 05 -> hex4 alternates 5/F and ledrhldr alternates 3FF/000 every 3 cycles; hex0 tracks mode.
REQ-040 userquit asserted in the same cycle as gameOver -> IDLE, all blank; resetn pulsed mid-PLAY -> reset values immediately.
